select_next_hop: RTL and testbench
==================================

Name: select_next_hop

Overview:
- Downstream of the cost-learning stage. Once neighbour Q-values are updated in the shared 2048x8 node memory, this block picks the next-hop neighbour by epsilon-greedy selection over the routing table.
- The greedy choice is the minimum qValue. Exploration picks a pseudo-random neighbour.
- Writes the chosen neighbour ID back to memory, exposes it on ports, and pulses done for the top-level sequencer.

Parameters:
LFSR_SEED, 16'hACE1, non-zero initial value of the exploration LFSR.
MAX_NEIGHBORS, 64, capacity of the neighbour table; the neighbour count is clamped to this value.

Ports:
clock  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  start request, sampled only in IDLE
data_in  in  16  memory read data; combinational for the current address
address  out  16  memory byte address (registered)
wr_en  out  1  memory write strobe; address and data_out are written at the clock edge
data_out  out  16  memory write data
next_hop  out  16  selected neighbour ID; holds until the next decision
next_hop_q  out  16  qValue of the selected neighbour
explored  out  1  1 means the last decision was exploratory
no_route  out  1  1 means the last decision found zero neighbours
done  out  1  high from decision completion until the next accepted en

Behaviour:
Memory map (word entries, 2-byte stride):
- epsilon at 16'h4
- neighborID at 16'h48+2n
- qValue at 16'h1C8+2n
- knownSinkCount at 16'h688
- neighborCount at 16'h68A
- nextHop at 16'h68C (new; written by this block)

Reset:
- All outputs 0, state IDLE, lfsr=LFSR_SEED.
- rst mid-operation aborts immediately, with no partial write; wr_en is 0 on the cycle after rst is sampled.

Read protocol: address is registered in state X; data_in is sampled in state X+1.

States, one cycle each:
- IDLE: on en, clear done/explored/no_route and go to A_NC. en while not IDLE is ignored.
- A_NC: address<=16'h68A.
- L_NC: nc<=min(data_in, MAX_NEIGHBORS); address<=16'h4.
- L_EPS: eps<=data_in. If nc==0: no_route<=1 and next_hop<=16'hFFFF, then go to WRITE. Otherwise n<=0, address<=16'h48, go to L_ID.
- L_ID: id_t<=data_in; address<=16'h1C8+2n.
- L_Q: if n==0 or data_in<best_q, take best_q/best_id/best_n. Comparison is unsigned strict less-than, so ties keep the lowest index. If n==nc-1 go to DECIDE; otherwise n<=n+1, address<=16'h48+2(n+1), go to L_ID.
- DECIDE: if lfsr<eps (unsigned), explored<=1, r<=lfsr[5:0], go to REDUCE. Otherwise next_hop<=best_id, next_hop_q<=best_q, go to WRITE.
- REDUCE: if r>=nc, r<=r-nc and stay (at most 63 cycles). Otherwise address<=16'h48+2r, go to L_XID.
- L_XID: next_hop<=data_in; address<=16'h1C8+2r.
- L_XQ: next_hop_q<=data_in, go to WRITE.
- WRITE: address<=16'h68C, data_out<=next_hop (16'hFFFF if no_route), wr_en<=1.
- WR_END: wr_en<=0.
- DONE: done<=1; lfsr advances exactly one step; go to IDLE.

LFSR and epsilon:
- LFSR is Fibonacci x^16+x^14+x^13+x^11+1, shifting left, with feedback into bit 0. It advances only in DONE, so one step per decision.
- eps=0 never explores. eps=16'hFFFF explores unless lfsr==16'hFFFF.

Latency:
- Greedy path: done rises 2N+7 cycles after the edge that samples en (N=nc).
- No-route path: done rises 6 cycles after that edge.
- Exactly one write per decision, always to 16'h68C.
- Arithmetic is 16-bit. Address offsets never exceed 16'h1C8+2*63.

Decomposition:
- Shared include: memory-map address constants (EPSILON, KNOWN_SINKS, NEIGHBOR_ID, CLUSTER_ID, BATTERY, QVALUE, SINK_IDS, KNOWN_SINK_CNT, NEIGHBOR_CNT, NEXT_HOP, SINK_ID_CNT), WORD_WIDTH, and the state encoding.
- One sub-module, hop_lfsr: 16-bit LFSR with seed parameter, step input and value output.

Test Plan:
- nc=3, q={30,10,20}, ids={7,9,4}, eps=0 -> next_hop=9, next_hop_q=10, explored=0. One write of 9 to 16'h68C; done at cycle 13.
- q={5,5,8}, ids={11,12,13}, eps=0 -> next_hop=11 (tie keeps lowest index).
- nc=0 -> no_route=1, next_hop=16'hFFFF. 16'hFFFF written to 16'h68C; done at cycle 6; no qValue/ID reads issued.
- eps=16'hFFFF, LFSR_SEED=16'h0005, nc=3, ids={7,9,4} -> explored=1, r=5 reduces to 2, next_hop=4. lfsr steps once after done.
- rst asserted during L_Q of a 4-neighbour scan -> wr_en=0 and all outputs 0 the next cycle; no write to 16'h68C. A new en then completes normally.
- en pulsed while busy, and nc register=100 -> en ignored; nc clamped to 64, scan reads indices 0..63 only.

Source files
------------

// File: rtl/select_next_hop_pkg.sv
// Shared definitions for the next-hop selection block: node-memory map,
// word width, FSM state encoding and the word-stride address helper.
package select_next_hop_pkg;

    localparam int WORD_WIDTH = 16;

    // Byte addresses of the word-sized entries in the shared node memory.
    localparam logic [15:0] EPSILON        = 16'h0004;
    localparam logic [15:0] KNOWN_SINKS    = 16'h0006;
    localparam logic [15:0] NEIGHBOR_ID    = 16'h0048;
    localparam logic [15:0] CLUSTER_ID     = 16'h00C8;
    localparam logic [15:0] BATTERY        = 16'h0148;
    localparam logic [15:0] QVALUE         = 16'h01C8;
    localparam logic [15:0] SINK_IDS       = 16'h0248;
    localparam logic [15:0] KNOWN_SINK_CNT = 16'h0688;
    localparam logic [15:0] NEIGHBOR_CNT   = 16'h068A;
    localparam logic [15:0] NEXT_HOP       = 16'h068C;
    localparam logic [15:0] SINK_ID_CNT    = 16'h068E;

    // Sentinel neighbour ID reported when the table is empty.
    localparam logic [15:0] NO_ROUTE_ID    = 16'hFFFF;

    // FSM state encoding; every state lasts one cycle except REDUCE.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_A_NC   = 4'd1;
    localparam logic [3:0] S_L_NC   = 4'd2;
    localparam logic [3:0] S_L_EPS  = 4'd3;
    localparam logic [3:0] S_L_ID   = 4'd4;
    localparam logic [3:0] S_L_Q    = 4'd5;
    localparam logic [3:0] S_DECIDE = 4'd6;
    localparam logic [3:0] S_REDUCE = 4'd7;
    localparam logic [3:0] S_L_XID  = 4'd8;
    localparam logic [3:0] S_L_XQ   = 4'd9;
    localparam logic [3:0] S_WRITE  = 4'd10;
    localparam logic [3:0] S_WR_END = 4'd11;
    localparam logic [3:0] S_DONE   = 4'd12;

    // Byte offset of table entry idx (entries are 2 bytes apart).
    function automatic logic [15:0] wordOffset(input logic [15:0] idx);
        return {idx[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/select_next_hop_lfsr.sv
// Exploration random source: 16-bit Fibonacci LFSR, polynomial
// x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
module hop_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Advance one position only when a step is requested.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Reload the seed on reset so the exploration sequence is reproducible.
    always_ff @(posedge clock) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/select_next_hop.sv
// Epsilon-greedy next-hop selector: scans the neighbour table for the
// minimum qValue, occasionally explores a pseudo-random neighbour, then
// writes the chosen ID to the NEXT_HOP slot and pulses done.
module select_next_hop #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          MAX_NEIGHBORS = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    output logic [15:0] next_hop,
    output logic [15:0] next_hop_q,
    output logic        explored,
    output logic        no_route,
    output logic        done
);

    import select_next_hop_pkg::*;

    localparam logic [15:0] NB_LIMIT = 16'(MAX_NEIGHBORS);

    logic [3:0]  state_q,    state_d;
    logic [15:0] address_q,  address_d;
    logic        wrEn_q,     wrEn_d;
    logic [15:0] dataOut_q,  dataOut_d;
    logic [15:0] nextHop_q,  nextHop_d;
    logic [15:0] nextHopQ_q, nextHopQ_d;
    logic        explored_q, explored_d;
    logic        noRoute_q,  noRoute_d;
    logic        done_q,     done_d;
    logic [15:0] nc_q,       nc_d;
    logic [15:0] eps_q,      eps_d;
    logic [15:0] n_q,        n_d;
    logic [15:0] idT_q,      idT_d;
    logic [15:0] bestQ_q,    bestQ_d;
    logic [15:0] bestId_q,   bestId_d;
    logic [15:0] r_q,        r_d;
    logic        lfsrStep;
    logic [15:0] lfsrValue;

    hop_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .rst     (rst),
        .step_i  (lfsrStep),
        .value_o (lfsrValue)
    );

    // Sequencing: fetch count and epsilon, scan the table, decide, write back.
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        wrEn_d     = 1'b0;
        dataOut_d  = dataOut_q;
        nextHop_d  = nextHop_q;
        nextHopQ_d = nextHopQ_q;
        explored_d = explored_q;
        noRoute_d  = noRoute_q;
        done_d     = done_q;
        nc_d       = nc_q;
        eps_d      = eps_q;
        n_d        = n_q;
        idT_d      = idT_q;
        bestQ_d    = bestQ_q;
        bestId_d   = bestId_q;
        r_d        = r_q;
        lfsrStep   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    done_d     = 1'b0;
                    explored_d = 1'b0;
                    noRoute_d  = 1'b0;
                    state_d    = S_A_NC;
                end
            end
            S_A_NC: begin
                address_d = NEIGHBOR_CNT;
                state_d   = S_L_NC;
            end
            S_L_NC: begin
                nc_d      = (data_in > NB_LIMIT) ? NB_LIMIT : data_in;
                address_d = EPSILON;
                state_d   = S_L_EPS;
            end
            S_L_EPS: begin
                eps_d = data_in;
                if (nc_q == 16'd0) begin
                    noRoute_d = 1'b1;
                    nextHop_d = NO_ROUTE_ID;
                    state_d   = S_WRITE;
                end else begin
                    n_d       = 16'd0;
                    address_d = NEIGHBOR_ID;
                    state_d   = S_L_ID;
                end
            end
            S_L_ID: begin
                idT_d     = data_in;
                address_d = QVALUE + wordOffset(n_q);
                state_d   = S_L_Q;
            end
            S_L_Q: begin
                if ((n_q == 16'd0) || (data_in < bestQ_q)) begin
                    bestQ_d  = data_in;
                    bestId_d = idT_q;
                end
                if (n_q == nc_q - 16'd1) begin
                    state_d = S_DECIDE;
                end else begin
                    n_d       = n_q + 16'd1;
                    address_d = NEIGHBOR_ID + wordOffset(n_q + 16'd1);
                    state_d   = S_L_ID;
                end
            end
            S_DECIDE: begin
                if (lfsrValue < eps_q) begin
                    explored_d = 1'b1;
                    r_d        = {10'd0, lfsrValue[5:0]};
                    state_d    = S_REDUCE;
                end else begin
                    nextHop_d  = bestId_q;
                    nextHopQ_d = bestQ_q;
                    state_d    = S_WRITE;
                end
            end
            S_REDUCE: begin
                if (r_q >= nc_q) begin
                    r_d = r_q - nc_q;
                end else begin
                    address_d = NEIGHBOR_ID + wordOffset(r_q);
                    state_d   = S_L_XID;
                end
            end
            S_L_XID: begin
                nextHop_d = data_in;
                address_d = QVALUE + wordOffset(r_q);
                state_d   = S_L_XQ;
            end
            S_L_XQ: begin
                nextHopQ_d = data_in;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                address_d = NEXT_HOP;
                dataOut_d = noRoute_q ? NO_ROUTE_ID : nextHop_q;
                wrEn_d    = 1'b1;
                state_d   = S_WR_END;
            end
            S_WR_END: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d   = 1'b1;
                lfsrStep = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any decision in flight without writing.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            address_q  <= 16'd0;
            wrEn_q     <= 1'b0;
            dataOut_q  <= 16'd0;
            nextHop_q  <= 16'd0;
            nextHopQ_q <= 16'd0;
            explored_q <= 1'b0;
            noRoute_q  <= 1'b0;
            done_q     <= 1'b0;
            nc_q       <= 16'd0;
            eps_q      <= 16'd0;
            n_q        <= 16'd0;
            idT_q      <= 16'd0;
            bestQ_q    <= 16'd0;
            bestId_q   <= 16'd0;
            r_q        <= 16'd0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wrEn_q     <= wrEn_d;
            dataOut_q  <= dataOut_d;
            nextHop_q  <= nextHop_d;
            nextHopQ_q <= nextHopQ_d;
            explored_q <= explored_d;
            noRoute_q  <= noRoute_d;
            done_q     <= done_d;
            nc_q       <= nc_d;
            eps_q      <= eps_d;
            n_q        <= n_d;
            idT_q      <= idT_d;
            bestQ_q    <= bestQ_d;
            bestId_q   <= bestId_d;
            r_q        <= r_d;
        end
    end

    assign address    = address_q;
    assign wr_en      = wrEn_q;
    assign data_out   = dataOut_q;
    assign next_hop   = nextHop_q;
    assign next_hop_q = nextHopQ_q;
    assign explored   = explored_q;
    assign no_route   = noRoute_q;
    assign done       = done_q;

endmodule

// File: tb/tb_select_next_hop.sv
// Self-checking bench for select_next_hop: directed scenarios followed by
// randomized tables, all compared against an epsilon-greedy reference model.
module tb_select_next_hop;

    logic        clock;
    logic        rst;
    logic        en;
    logic [15:0] data_in;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic [15:0] next_hop;
    logic [15:0] next_hop_q;
    logic        explored;
    logic        no_route;
    logic        done;

    localparam logic [15:0] SEED = 16'h0005;

    // Word-addressed node memory image; the DUT reads it combinationally.
    logic [15:0] mem [0:32767];
    assign data_in = mem[address[15:1]];

    // Table contents for the current scenario.
    logic [15:0] qArr  [0:63];
    logic [15:0] idArr [0:63];
    int          curNc;
    logic [15:0] curEps;
    logic [15:0] lfsrModel;

    int          checks = 0;
    int          errors = 0;
    int          writeCount = 0;
    logic [15:0] lastWriteAddr = 16'd0;
    logic [15:0] lastWriteData = 16'd0;
    int          maxIdxRead = -1;

    select_next_hop #(.LFSR_SEED(SEED), .MAX_NEIGHBORS(64)) dut (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .address    (address),
        .wr_en      (wr_en),
        .data_out   (data_out),
        .next_hop   (next_hop),
        .next_hop_q (next_hop_q),
        .explored   (explored),
        .no_route   (no_route),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record memory writes and the highest table index the DUT touches.
    always @(posedge clock) begin
        if (wr_en) begin
            writeCount    = writeCount + 1;
            lastWriteAddr = address;
            lastWriteData = data_out;
        end
        if (address >= 16'h0048 && address < 16'h00C8) begin
            if (int'((address - 16'h0048) >> 1) > maxIdxRead) maxIdxRead = int'((address - 16'h0048) >> 1);
        end
        if (address >= 16'h01C8 && address < 16'h0248) begin
            if (int'((address - 16'h01C8) >> 1) > maxIdxRead) maxIdxRead = int'((address - 16'h01C8) >> 1);
        end
    end

    // One comparison: count it, and report tag/observed/expected if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load the neighbour count, epsilon and table arrays into memory.
    task automatic applyStimulus(input int nc, input logic [15:0] eps);
        curNc  = nc;
        curEps = eps;
        mem[16'h068A >> 1] = 16'(nc);
        mem[16'h0004 >> 1] = eps;
        for (int i = 0; i < 64; i++) begin
            mem[(16'h0048 >> 1) + i] = idArr[i];
            mem[(16'h01C8 >> 1) + i] = qArr[i];
        end
    endtask

    // Every output must read zero after reset.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_address"},  32'(address),    0);
        checkOutput({tag, "_wr_en"},    32'(wr_en),      0);
        checkOutput({tag, "_data_out"}, 32'(data_out),   0);
        checkOutput({tag, "_next_hop"}, 32'(next_hop),   0);
        checkOutput({tag, "_hop_q"},    32'(next_hop_q), 0);
        checkOutput({tag, "_explored"}, 32'(explored),   0);
        checkOutput({tag, "_no_route"}, 32'(no_route),   0);
        checkOutput({tag, "_done"},     32'(done),       0);
    endtask

    // One polynomial step: feedback is the parity of the tapped bits 16,14,13,11.
    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    // Start one decision, wait for done within a bound, and compare everything
    // against the reference model. busyEnAt re-pulses en mid-decision.
    task automatic runDecision(input string tag, input int busyEnAt);
        int          ncEff, bestI, rv, expLat, cycles, w0;
        logic [15:0] expHop, expQ;
        logic        expExp, expNr, seen;
        ncEff  = (curNc > 64) ? 64 : curNc;
        expNr  = (ncEff == 0);
        expExp = 1'b0;
        expHop = 16'hFFFF;
        expQ   = 16'd0;
        expLat = 6;
        if (!expNr) begin
            bestI = 0;
            for (int i = 1; i < ncEff; i++) if (qArr[i] < qArr[bestI]) bestI = i;
            rv = int'(lfsrModel & 16'h003F);
            if (lfsrModel < curEps) begin
                expExp = 1'b1;
                expHop = idArr[rv % ncEff];
                expQ   = qArr[rv % ncEff];
                expLat = 2 * ncEff + 10 + rv / ncEff;
            end else begin
                expHop = idArr[bestI];
                expQ   = qArr[bestI];
                expLat = 2 * ncEff + 7;
            end
        end
        w0 = writeCount;
        maxIdxRead = -1;
        @(negedge clock);
        en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
        checkOutput({tag, "_doneCleared"}, 32'(done), 0);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 400) begin
            @(posedge clock);
            cycles++;
            #1 en = (cycles == busyEnAt);
            if (done) seen = 1'b1;
        end
        en = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_timeout observed=no done expected=done in %0d cycles", tag, expLat);
        end else begin
            checkOutput({tag, "_latency"},  32'(cycles),     32'(expLat));
            checkOutput({tag, "_next_hop"}, 32'(next_hop),   32'(expHop));
            if (!expNr) checkOutput({tag, "_hop_q"}, 32'(next_hop_q), 32'(expQ));
            checkOutput({tag, "_explored"}, 32'(explored),   32'(expExp));
            checkOutput({tag, "_no_route"}, 32'(no_route),   32'(expNr));
            checkOutput({tag, "_writes"},   32'(writeCount - w0), 1);
            checkOutput({tag, "_wrAddr"},   32'(lastWriteAddr), 32'h068C);
            checkOutput({tag, "_wrData"},   32'(lastWriteData), 32'(expHop));
            checkOutput({tag, "_maxIdx"},   32'(maxIdxRead), 32'(ncEff - 1));
        end
        lfsrModel = lfsrNext(lfsrModel);
    endtask

    initial begin
        int w0, cycles;
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'd0;
        for (int i = 0; i < 64; i++) begin
            qArr[i]  = 16'd0;
            idArr[i] = 16'd0;
        end
        lfsrModel = SEED;
        repeat (3) @(posedge clock);
        #1 checkAllZero("reset");
        @(negedge clock) rst = 1'b0;

        // Exploration from the seed: r=5 reduces to 2, then the next step gives r=10 -> 1.
        $display("[TB] exploration");
        qArr[0] = 16'd30; qArr[1] = 16'd10; qArr[2] = 16'd20;
        idArr[0] = 16'd7; idArr[1] = 16'd9; idArr[2] = 16'd4;
        applyStimulus(3, 16'hFFFF);
        runDecision("explore1", -1);
        runDecision("explore2", -1);

        // Greedy minimum and tie-breaking towards the lowest index.
        $display("[TB] greedy");
        applyStimulus(3, 16'h0000);
        runDecision("greedy", -1);
        qArr[0] = 16'd5; qArr[1] = 16'd5; qArr[2] = 16'd8;
        idArr[0] = 16'd11; idArr[1] = 16'd12; idArr[2] = 16'd13;
        applyStimulus(3, 16'h0000);
        runDecision("tie", -1);

        // Empty table.
        $display("[TB] no route");
        applyStimulus(0, 16'h0000);
        runDecision("noroute", -1);

        // Reset in the middle of a 4-neighbour scan (first L_Q cycle).
        $display("[TB] reset mid-scan");
        qArr[3] = 16'd1; idArr[3] = 16'd21;
        applyStimulus(4, 16'h0000);
        w0 = writeCount;
        @(negedge clock) en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
        cycles = 0;
        while (cycles < 4) begin
            @(posedge clock);
            cycles++;
        end
        #1 rst = 1'b1;
        @(posedge clock);
        #1 checkAllZero("midReset");
        rst = 1'b0;
        lfsrModel = SEED;
        repeat (6) @(posedge clock);
        #1 checkOutput("midReset_noWrite", 32'(writeCount - w0), 0);
        checkOutput("midReset_idleDone", 32'(done), 0);
        runDecision("afterReset", -1);

        // Oversized count is clamped; a busy-time en is ignored.
        $display("[TB] clamp and busy en");
        for (int i = 0; i < 64; i++) begin
            qArr[i]  = 16'(200 - i);
            idArr[i] = 16'(1000 + i);
        end
        qArr[40] = 16'd3;
        for (int i = 64; i < 100; i++) begin
            mem[(16'h0048 >> 1) + i] = 16'hDEAD;
            mem[(16'h01C8 >> 1) + i] = 16'd0;
        end
        applyStimulus(100, 16'h0000);
        runDecision("clamp", 3);
        repeat (3) @(posedge clock);
        #1 checkOutput("clamp_stillDone", 32'(done), 1);

        // Randomized tables and epsilons.
        $display("[TB] random");
        for (int t = 0; t < 20; t++) begin
            logic [15:0] e;
            int sel;
            for (int i = 0; i < 64; i++) begin
                qArr[i]  = 16'($urandom_range(0, 7));
                idArr[i] = 16'($urandom);
            end
            sel = int'($urandom_range(0, 2));
            e = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            applyStimulus(int'($urandom_range(0, 9)), e);
            runDecision($sformatf("rand%0d", t), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
